// File: rtl/fifo_rd_stream_pkg.sv
// Shared defaults, types and helpers for the FIFO read-side drain stage.
package fifo_rd_stream_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 9;
  localparam int unsigned DEF_SKID_DEPTH = 4;
  localparam int unsigned DEF_BURST_LEN  = 16;

  typedef logic [DEF_DATA_WIDTH-1:0]        word_t;
  typedef logic [$clog2(DEF_SKID_DEPTH):0] count_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Circular skid buffer: storage, read/write pointers and occupancy count.
module rd_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_SKID_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("rd_skid_buf: DEPTH must be a power of two >= 2");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [CntW-1:0]       count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is reset so the stream data reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wptr_q] <= wr_data;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (rd_en) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign rd_data = mem_q[rptr_q];
  assign count   = count_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= Full);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(wr_en && !rd_en && count_q == Full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(rd_en && count_q == '0));

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain: pops into a skid buffer and presents a valid/ready stream.
// Define FIFO_RD_STREAM_LAST_EN to frame the stream into BURST_LEN-word packets.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned SKID_DEPTH = DEF_SKID_DEPTH,
  parameter int unsigned BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                  R_CLK,
  input  logic                  RRST_n,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  R_EN,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OUT_LAST
);

  localparam int unsigned CntW = $clog2(SKID_DEPTH) + 1;
  localparam logic [CntW:0] ResvMax = (CntW + 1)'(SKID_DEPTH);

  if (BURST_LEN < 1) begin : g_bad_burst
    $error("fifo_rd_stream: BURST_LEN must be >= 1");
  end

  logic            inflight_q;
  logic [CntW-1:0] count;
  logic [CntW:0]   reserved;
  logic            pop;

  // Buffered words plus the one still on its way from the FIFO.
  assign reserved = {1'b0, count} + {{CntW{1'b0}}, inflight_q};

  // Held low in reset since the FIFO read side shares the same reset.
  assign R_EN      = RRST_n && !EMPTY && (reserved < ResvMax);
  assign OUT_VALID = (count != '0);
  assign pop       = OUT_VALID && OUT_READY;

  always_ff @(posedge R_CLK or negedge RRST_n) begin
    if (!RRST_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= R_EN;
    end
  end

  rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (SKID_DEPTH)
  ) u_skid (
    .clk    (R_CLK),
    .rst_n  (RRST_n),
    .wr_en  (inflight_q),
    .wr_data(RD_DATA),
    .rd_en  (pop),
    .rd_data(OUT_DATA),
    .count  (count)
  );

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam int unsigned BurstW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BurstW-1:0] LastIdx = BurstW'(BURST_LEN - 1);

  logic [BurstW-1:0] burst_q, burst_d;

  assign OUT_LAST = OUT_VALID && (burst_q == LastIdx);

  always_comb begin
    burst_d = burst_q;
    if (pop) begin
      burst_d = OUT_LAST ? '0 : burst_q + 1'b1;
    end
  end

  always_ff @(posedge R_CLK or negedge RRST_n) begin
    if (!RRST_n) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign OUT_LAST = 1'b0;
`endif

  a_no_pop_when_empty: assert property (@(posedge R_CLK) disable iff (!RRST_n)
                                        R_EN |-> !EMPTY);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: directed vector table plus a queue-based stream model.
module tb_fifo_rd_stream;

  localparam int DW = 9;
  localparam int SD = 4;
  localparam int BL = 16;
`ifdef FIFO_RD_STREAM_LAST_EN
  localparam bit LastEn = 1'b1;
`else
  localparam bit LastEn = 1'b0;
`endif

  logic          R_CLK = 1'b0;
  logic          RRST_n;
  logic          EMPTY;
  logic [DW-1:0] RD_DATA;
  logic          R_EN;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic          OUT_LAST;

  always #5 R_CLK = ~R_CLK;

  fifo_rd_stream #(
    .DATA_WIDTH(DW),
    .SKID_DEPTH(SD),
    .BURST_LEN (BL)
  ) dut (
    .R_CLK    (R_CLK),
    .RRST_n   (RRST_n),
    .EMPTY    (EMPTY),
    .RD_DATA  (RD_DATA),
    .R_EN     (R_EN),
    .OUT_DATA (OUT_DATA),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_LAST (OUT_LAST)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  typedef struct {
    bit          empty;
    bit          ready;
    logic [DW-1:0] rd;
    bit          r_en;
    bit          valid;
    bit          chk_d;
    logic [DW-1:0] data;
  } vec_t;
  vec_t vecs[15];

  // Stream model: source FIFO contents, popped words with the cycle they become visible.
  typedef struct {
    logic [DW-1:0] d;
    int            arr;
  } ent_t;
  logic [DW-1:0] src_q[$];
  ent_t          pend_q[$];
  int            cyc;
  bit            have_rd;
  logic [DW-1:0] rd_word;
  int            acc_cnt;
  int            ren_cnt;

  function automatic int arrived(input int upto);
    int n = 0;
    foreach (pend_q[i]) if (pend_q[i].arr <= upto) n++;
    return n;
  endfunction

  task automatic model_cycle(input int rmode, input bit tog);
    bit exp_ren, exp_valid, exp_last;
    @(posedge R_CLK);
    #1;
    RD_DATA = have_rd ? rd_word : DW'($urandom);
    EMPTY   = (src_q.size() == 0) || (tog && (cyc % 2 == 1));
    case (rmode)
      0:       OUT_READY = 1'b0;
      1:       OUT_READY = 1'b1;
      default: OUT_READY = 1'($urandom_range(0, 1));
    endcase
    @(negedge R_CLK);
    exp_ren   = !EMPTY && (pend_q.size() < SD);
    exp_valid = (pend_q.size() > 0) && (pend_q[0].arr <= cyc);
    exp_last  = LastEn && exp_valid && (acc_cnt % BL == BL - 1);
    chk("r_en", R_EN, exp_ren);
    chk("out_valid", OUT_VALID, exp_valid);
    if (exp_valid) chk("out_data", OUT_DATA, pend_q[0].d);
    chk("out_last", OUT_LAST, exp_last);
    have_rd = 1'b0;
    if (R_EN === 1'b1 && !EMPTY && src_q.size() > 0) begin
      rd_word = src_q.pop_front();
      have_rd = 1'b1;
      pend_q.push_back('{d: rd_word, arr: cyc + 2});
      ren_cnt++;
    end
    if (exp_valid && OUT_READY) begin
      void'(pend_q.pop_front());
      acc_cnt++;
    end
    cyc++;
  endtask

  task automatic drain(input int rmode, input bit tog, input int budget, input string nm);
    int n = 0;
    while ((src_q.size() > 0 || pend_q.size() > 0) && n < budget) begin
      model_cycle(rmode, tog);
      n++;
    end
    chk(nm, src_q.size() + pend_q.size(), 0);
  endtask

  task automatic clear_model();
    src_q.delete();
    pend_q.delete();
    have_rd = 1'b0;
    acc_cnt = 0;
    cyc     = 0;
  endtask

  task automatic do_reset();
    RRST_n    = 1'b0;
    EMPTY     = 1'b1;
    OUT_READY = 1'b0;
    repeat (2) @(posedge R_CLK);
    @(negedge R_CLK);
    RRST_n = 1'b1;
    clear_model();
  endtask

  initial begin
    vecs[0]  = '{1, 0, 9'h000, 0, 0, 1, 9'h000};
    vecs[1]  = '{0, 0, 9'h155, 1, 0, 0, 9'h000};
    vecs[2]  = '{0, 0, 9'h0A1, 1, 0, 0, 9'h000};
    vecs[3]  = '{0, 0, 9'h0A2, 1, 1, 1, 9'h0A1};
    vecs[4]  = '{0, 0, 9'h0A3, 1, 1, 1, 9'h0A1};
    vecs[5]  = '{0, 0, 9'h0A4, 0, 1, 1, 9'h0A1};
    vecs[6]  = '{0, 0, 9'h155, 0, 1, 1, 9'h0A1};
    vecs[7]  = '{0, 1, 9'h155, 0, 1, 1, 9'h0A1};
    vecs[8]  = '{0, 1, 9'h155, 1, 1, 1, 9'h0A2};
    vecs[9]  = '{0, 1, 9'h0A5, 1, 1, 1, 9'h0A3};
    vecs[10] = '{1, 1, 9'h0A6, 0, 1, 1, 9'h0A4};
    vecs[11] = '{1, 1, 9'h155, 0, 1, 1, 9'h0A5};
    vecs[12] = '{1, 0, 9'h155, 0, 1, 1, 9'h0A6};
    vecs[13] = '{1, 1, 9'h155, 0, 1, 1, 9'h0A6};
    vecs[14] = '{1, 0, 9'h155, 0, 0, 0, 9'h000};

    RRST_n    = 1'b0;
    EMPTY     = 1'b1;
    OUT_READY = 1'b0;
    RD_DATA   = '0;
    clear_model();
    #12;
    chk("rst_r_en", R_EN, 0);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_data", OUT_DATA, 0);
    chk("rst_last", OUT_LAST, 0);
    @(negedge R_CLK);
    RRST_n = 1'b1;

    // Directed table: fill to full under backpressure, then drain with a pop overlap.
    for (int i = 0; i < 15; i++) begin
      @(posedge R_CLK);
      #1;
      EMPTY     = vecs[i].empty;
      OUT_READY = vecs[i].ready;
      RD_DATA   = vecs[i].rd;
      @(negedge R_CLK);
      chk($sformatf("vec%0d_r_en", i), R_EN, vecs[i].r_en);
      chk($sformatf("vec%0d_valid", i), OUT_VALID, vecs[i].valid);
      if (vecs[i].chk_d) chk($sformatf("vec%0d_data", i), OUT_DATA, vecs[i].data);
      chk($sformatf("vec%0d_last", i), OUT_LAST, 0);
    end

    // Streaming at full rate.
    do_reset();
    for (int w = 1; w <= 32; w++) src_q.push_back(DW'(w));
    ren_cnt = 0;
    drain(1, 1'b0, 200, "stream_done");
    chk("stream_pops", ren_cnt, 32);

    // Backpressure with a full FIFO: exactly SD pops, head word held.
    for (int w = 0; w < 8; w++) src_q.push_back(DW'(9'h100 + w));
    ren_cnt = 0;
    repeat (12) model_cycle(0, 1'b0);
    chk("bp_pops", ren_cnt, SD);
    chk("bp_head", OUT_DATA, 9'h100);
    drain(1, 1'b0, 200, "bp_done");

    // EMPTY toggling every cycle.
    for (int w = 0; w < 40; w++) src_q.push_back(DW'($urandom));
    drain(2, 1'b1, 1000, "underflow_done");

    // Random ready over 1000 words.
    for (int w = 0; w < 1000; w++) src_q.push_back(DW'($urandom));
    drain(2, 1'b0, 10000, "random_done");

    // Packet framing from a fresh burst count.
    do_reset();
    for (int w = 1; w <= 40; w++) src_q.push_back(DW'(w));
    drain(1, 1'b0, 400, "frame_done");

    // Reset mid-stream with three buffered words.
    do_reset();
    for (int w = 0; w < 10; w++) src_q.push_back(DW'(9'h1C0 + w));
    begin
      int n = 0;
      while (arrived(cyc - 1) < 3 && n < 20) begin
        model_cycle(0, 1'b0);
        n++;
      end
      chk("mid_buffered", arrived(cyc - 1), 3);
    end
    chk("mid_valid_pre", OUT_VALID, 1);
    #1;
    RRST_n = 1'b0;
    #1;
    chk("mid_rst_r_en", R_EN, 0);
    chk("mid_rst_valid", OUT_VALID, 0);
    chk("mid_rst_data", OUT_DATA, 0);
    chk("mid_rst_last", OUT_LAST, 0);
    EMPTY = 1'b1;
    @(negedge R_CLK);
    RRST_n = 1'b1;
    clear_model();
    repeat (5) model_cycle(1, 1'b0);
    for (int w = 0; w < 5; w++) src_q.push_back(DW'(9'h0E0 + w));
    drain(1, 1'b0, 100, "post_rst_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain stage for the asynchronous FIFO, in the read clock domain. Pops words whenever the FIFO is non-empty and buffer space is reserved, absorbs the FIFO's one-cycle registered read latency in a small skid buffer, and presents the words on a valid/ready stream to downstream logic. An optional burst counter frames the stream into fixed-length packets.

## Interface
- DATA_WIDTH, 9, word width; matches FIFO data width
- SKID_DEPTH, 4, skid buffer entries; power of two, ≥ 2
- BURST_LEN, 16, words per packet (framing build only); ≥ 1
- R_CLK  input  1  read clock; all logic on rising edge
- RRST_n  input  1  asynchronous active-low reset (shared with FIFO read side)
- EMPTY  input  1  FIFO empty flag, R_CLK domain
- RD_DATA  input  DATA_WIDTH  FIFO read data; valid the cycle after R_EN=1
- R_EN  output  1  FIFO pop request
- OUT_DATA  output  DATA_WIDTH  stream data
- OUT_VALID  output  1  stream valid
- OUT_READY  input  1  downstream ready
- OUT_LAST  output  1  last word of packet (framing build only; else tied 0)

## Operation
- State: inflight (1 bit, a pop issued last cycle), occupancy count (0..SKID_DEPTH), read/write pointers (log2 SKID_DEPTH bits, wrap naturally).
- R_EN = !EMPTY && (count + inflight < SKID_DEPTH); combinational from registered state and EMPTY only, never from OUT_READY.
- inflight <= R_EN each cycle; when inflight=1, RD_DATA is written at write pointer.
- OUT_VALID = (count != 0); OUT_DATA = entry at read pointer (combinational from storage).
- Pop on OUT_VALID && OUT_READY.
- Simultaneous write and pop: count unchanged, both pointers advance.
- Full: count + inflight = SKID_DEPTH -> R_EN held 0; overflow impossible by construction (assert count ≤ SKID_DEPTH).
- Empty skid and EMPTY=1: OUT_VALID=0, R_EN=0, no state change.
- OUT_VALID, once asserted, stays asserted with OUT_DATA stable until accepted.
- Reset values: R_EN=0, OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, count=0, inflight=0, pointers=0, burst counter=0.
- Reset mid-operation: in-flight and buffered words discarded; FIFO read side resets on the same RRST_n, so no word is lost relative to the FIFO state.

## Timing
- Latency: FIFO word visible on OUT_DATA 2 cycles after EMPTY falls (R_EN cycle 0, RD_DATA capture at the cycle-1 edge, OUT_VALID in cycle 2).
- Throughput: 1 word/cycle sustained with OUT_READY=1 and FIFO non-empty.
- Backpressure: at most SKID_DEPTH words accepted after OUT_READY falls; R_EN drops no later than the cycle the reservation reaches SKID_DEPTH.
- Reset assertion clears outputs immediately (asynchronous); deassertion is assumed synchronised to R_CLK upstream.

## Configuration
- FIFO_RD_STREAM_LAST_EN defined: burst counter (width clog2(BURST_LEN)) increments on each handshake. OUT_LAST=1 while OUT_VALID and counter = BURST_LEN-1; counter wraps to 0 on that handshake. BURST_LEN=1 -> OUT_LAST=OUT_VALID.
- Not defined: no counter; OUT_LAST constant 0.

## Structure
- Package fifo_rd_stream_pkg: default DATA_WIDTH/SKID_DEPTH/BURST_LEN constants, typedef word_t (DATA_WIDTH bits), typedef count_t (clog2(SKID_DEPTH)+1 bits).
- One sub-module rd_skid_buf: circular buffer storage, pointers and occupancy count; the top holds R_EN/inflight logic and framing.

## Test plan
- Reset: RRST_n=0 mid-stream with 3 buffered words -> all outputs 0 immediately; after release, OUT_VALID=0 until new data.
- Streaming: FIFO holds 0x001..0x020, OUT_READY=1 -> R_EN every cycle; OUT_DATA 0x001..0x020 in order, one per cycle from the second cycle after R_EN first rises; no gaps.
- Backpressure: OUT_READY=0 with FIFO full -> exactly SKID_DEPTH (4) pops, R_EN then 0; OUT_DATA stable at the first word; on release, the stream resumes with no loss or duplication.
- Underflow: EMPTY toggles 1/0 each cycle -> R_EN never high while EMPTY=1; output sequence intact.
- Random ready: 1000 words, 50% random OUT_READY -> scoreboard exact match; assertions count ≤ SKID_DEPTH and no R_EN while EMPTY=1 hold.
- Framing (FIFO_RD_STREAM_LAST_EN, BURST_LEN=16): 40 words -> OUT_LAST on words 16 and 32 only; word 33 starts a new packet.
